trng_crngt: RTL and testbench
=============================

TRNG_CRNGT -- requirements
Module: trng_crngt

Interface
REQ-001 Parameter DATA_W, 16, width of the collector word and the EHR word.
REQ-002 Parameter CNT_W, 16, width of the saturating pass-word counter.
REQ-003 rng_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 rst_trng_logic  in  1  synchronous soft reset of the TRNG datapath.
REQ-006 crngt_en  in  1  enables the test; low parks the block in IDLE.
REQ-007 collector_valid  in  1  collector holds a full 16-bit word.
REQ-008 collector_crngt_data  in  DATA_W  collector word; stable while collector_valid=1.
REQ-009 crngt_collector_rd  out  1  one-cycle read strobe; the collector clears on rd&valid.
REQ-010 crngt_ehr_valid  out  1  forwarded word available to the EHR.
REQ-011 crngt_ehr_data  out  DATA_W  forwarded word; stable while crngt_ehr_valid=1.
REQ-012 ehr_crngt_ready  in  1  EHR accepts the word this cycle.
REQ-013 crngt_err  out  1  sticky failure: two consecutive words were equal.
REQ-014 crngt_pass_cnt  out  CNT_W  count of words forwarded, saturating.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RD, CMP, PUSH and FAIL; all outputs are registered or Moore-decoded.
REQ-016 IDLE: crngt_en=1 -> WAIT, and the first_q flag is set.
REQ-017 WAIT: crngt_en=0 -> IDLE; otherwise collector_valid=1 -> RD.
REQ-018 RD: crngt_collector_rd=1 for exactly one cycle; cur_q captures collector_crngt_data; next state CMP.
REQ-019 CMP with first_q=1: prev_q<=cur_q, first_q<=0, no push, next state WAIT.
REQ-020 CMP with first_q=0 and cur_q==prev_q: crngt_err<=1, next state FAIL, no push.
REQ-021 CMP with first_q=0 and cur_q!=prev_q: prev_q<=cur_q, crngt_ehr_data<=cur_q, next state PUSH.
REQ-022 PUSH: crngt_ehr_valid=1; data is held until ehr_crngt_ready=1.
REQ-023 On the PUSH handshake, crngt_pass_cnt increments (saturating at all-ones) and the FSM moves to WAIT; crngt_en is ignored in RD, CMP and PUSH.
REQ-024 Latency, non-first word: collector_valid seen in WAIT at cycle N gives rd at N+1, CMP at N+2 and crngt_ehr_valid at N+3; the earliest next rd is at N+5.
REQ-025 FAIL: no rd and no push; the block stays in FAIL until rst or rst_trng_logic, and crngt_en has no effect.
REQ-026 Comparison covers all DATA_W bits; equality of 0x0000 or 0xFFFF is treated like any other value.
REQ-027 rst_trng_logic SHALL take priority over every FSM transition: next cycle IDLE, all outputs 0, prev_q/cur_q=0, first_q=1.
REQ-028 crngt_ehr_valid=1 and rst_trng_logic=1 in the same cycle: the word is dropped and crngt_pass_cnt does not increment.
REQ-029 If collector_valid is already high when entering WAIT, the FSM moves to RD on the next cycle with no extra wait.

Reset
REQ-030 rst=1 SHALL asynchronously force: FSM to IDLE, crngt_collector_rd=0, crngt_ehr_valid=0, crngt_ehr_data=0, crngt_err=0, crngt_pass_cnt=0, prev_q=0, cur_q=0, first_q=1.
REQ-031 A reset asserted mid-PUSH SHALL discard the pending word; after reset the next word is again treated as first.

Structure
REQ-032 A shared package trng_pkg SHALL hold DATA_W, CNT_W and the state enum trng_crngt_state_t (IDLE, WAIT, RD, CMP, PUSH, FAIL).
REQ-033 One sub-module, trng_sat_cnt (parameterised saturating counter with inc and clr), SHALL implement crngt_pass_cnt; everything else is flat.

Verification
REQ-034 Reset, then crngt_en=1, words 0x1234, 0x5678, 0xABCD with ready=1 -> no push for 0x1234; pushes 0x5678 then 0xABCD; pass_cnt=2; crngt_err=0.
REQ-035 Words 0x1111, 0x2222, 0x2222 -> 0x2222 pushed once; crngt_err=1 three cycles after the third valid; no further rd while collector_valid stays high.
REQ-036 Word pushed with ready held low 10 cycles -> crngt_ehr_valid and data stable for 10 cycles; no rd until two cycles after the handshake.
REQ-037 FAIL state, then rst_trng_logic pulse -> crngt_err=0 and IDLE next cycle; with crngt_en=1 the next word 0x2222 is treated as first and not flagged.
REQ-038 rst asserted during PUSH -> valid drops asynchronously; pass_cnt=0; first_q=1.
REQ-039 pass_cnt preloaded/forced near all-ones, then 3 good pushes -> pass_cnt holds 0xFFFF.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG continuous random-number generator test
// (CRNGT) slice: default word and counter widths plus the CRNGT FSM state type.
package trng_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    RD   = 3'd2,
    CMP  = 3'd3,
    PUSH = 3'd4,
    FAIL = 3'd5
  } trng_crngt_state_t;

endpackage

// File: rtl/trng_sat_cnt.sv
// Saturating up-counter.
// Ports:
//   rng_clk  clock
//   rst      asynchronous active-high reset, clears the count
//   clr      synchronous clear, has priority over inc
//   inc      add one unless already at all-ones
//   q        current count
module trng_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             rng_clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge rng_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/trng_crngt.sv
// Continuous random-number generator test. Reads words from the collector,
// compares each one with the previous word and forwards it to the EHR only if
// it differs. Two consecutive equal words latch a sticky error and park the
// FSM in FAIL until a hard or soft reset. The first word after (re)start is
// only stored as the comparison reference and never forwarded.
// Ports:
//   rng_clk, rst                 clock, asynchronous active-high reset
//   rst_trng_logic               synchronous soft reset of the datapath
//   crngt_en                     enable; low parks the block in IDLE
//   collector_valid/_crngt_data  incoming word from the collector
//   crngt_collector_rd           one-cycle read strobe back to the collector
//   crngt_ehr_valid/_data        forwarded word, held until ehr_crngt_ready
//   ehr_crngt_ready              EHR accepts the word
//   crngt_err                    sticky repeated-word failure
//   crngt_pass_cnt               saturating count of forwarded words
module trng_crngt
  import trng_pkg::*;
#(
  parameter int DATA_W = trng_pkg::DATA_W,
  parameter int CNT_W  = trng_pkg::CNT_W
) (
  input  logic              rng_clk,
  input  logic              rst,
  input  logic              rst_trng_logic,
  input  logic              crngt_en,
  input  logic              collector_valid,
  input  logic [DATA_W-1:0] collector_crngt_data,
  output logic              crngt_collector_rd,
  output logic              crngt_ehr_valid,
  output logic [DATA_W-1:0] crngt_ehr_data,
  input  logic              ehr_crngt_ready,
  output logic              crngt_err,
  output logic [CNT_W-1:0]  crngt_pass_cnt
);

  trng_crngt_state_t state_q, state_d;
  logic [DATA_W-1:0] cur_q, prev_q, ehr_data_q;
  logic              first_q, err_q;
  logic              same_word;
  logic              push_done;

  assign same_word = (cur_q == prev_q);
  assign push_done = (state_q == PUSH) && ehr_crngt_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (crngt_en) state_d = WAIT;
      WAIT: begin
        if (!crngt_en)            state_d = IDLE;
        else if (collector_valid) state_d = RD;
      end
      RD:   state_d = CMP;
      CMP: begin
        if (first_q)        state_d = WAIT;
        else if (same_word) state_d = FAIL;
        else                state_d = PUSH;
      end
      PUSH: if (ehr_crngt_ready) state_d = WAIT;
      FAIL: state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  // Soft reset overrides every transition and also discards a pending push.
  always_ff @(posedge rng_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      prev_q     <= '0;
      ehr_data_q <= '0;
      first_q    <= 1'b1;
      err_q      <= 1'b0;
    end else if (rst_trng_logic) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      prev_q     <= '0;
      ehr_data_q <= '0;
      first_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (crngt_en) first_q <= 1'b1;
        RD:   cur_q <= collector_crngt_data;
        CMP: begin
          if (first_q) begin
            prev_q  <= cur_q;
            first_q <= 1'b0;
          end else if (same_word) begin
            err_q <= 1'b1;
          end else begin
            prev_q     <= cur_q;
            ehr_data_q <= cur_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign crngt_collector_rd = (state_q == RD);
  assign crngt_ehr_valid    = (state_q == PUSH);
  assign crngt_ehr_data     = ehr_data_q;
  assign crngt_err          = err_q;

  trng_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_pass_cnt (
    .rng_clk (rng_clk),
    .rst     (rst),
    .clr     (rst_trng_logic),
    .inc     (push_done && !rst_trng_logic),
    .q       (crngt_pass_cnt)
  );

endmodule

// File: tb/tb_trng_crngt.sv
module tb_trng_crngt;

  logic        rng_clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_trng_logic = 1'b0;
  logic        crngt_en = 1'b0;
  logic        collector_valid = 1'b0;
  logic [15:0] collector_crngt_data = 16'h0;
  logic        crngt_collector_rd;
  logic        crngt_ehr_valid;
  logic [15:0] crngt_ehr_data;
  logic        ehr_crngt_ready = 1'b0;
  logic        crngt_err;
  logic [15:0] crngt_pass_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  always #5 rng_clk = ~rng_clk;

  trng_crngt dut (
    .rng_clk              (rng_clk),
    .rst                  (rst),
    .rst_trng_logic       (rst_trng_logic),
    .crngt_en             (crngt_en),
    .collector_valid      (collector_valid),
    .collector_crngt_data (collector_crngt_data),
    .crngt_collector_rd   (crngt_collector_rd),
    .crngt_ehr_valid      (crngt_ehr_valid),
    .crngt_ehr_data       (crngt_ehr_data),
    .ehr_crngt_ready      (ehr_crngt_ready),
    .crngt_err            (crngt_err),
    .crngt_pass_cnt       (crngt_pass_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every EHR handshake must match the oldest expected word.
  always @(negedge rng_clk) begin
    if (!rst && crngt_ehr_valid && ehr_crngt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push: got %0h expected none", crngt_ehr_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (crngt_ehr_data !== e) begin
          errors++;
          $display("FAIL push_data: got %0h expected %0h", crngt_ehr_data, e);
        end
      end
    end
  end

  // Collector model: hold the word until the read strobe, clear after it.
  // Returns just after the posedge that ends the RD cycle (now in CMP).
  task automatic send_word(input logic [15:0] w);
    int n;
    n = 0;
    collector_valid      = 1'b1;
    collector_crngt_data = w;
    do begin
      @(negedge rng_clk);
      n++;
    end while (!crngt_collector_rd && n < 20);
    checks++;
    if (!crngt_collector_rd) begin
      errors++;
      $display("FAIL rd_timeout: got 0 expected 1 for word %0h", w);
    end
    @(posedge rng_clk);
    #1;
    collector_valid = 1'b0;
  endtask

  // Word expected to be forwarded: checks CMP then PUSH latency.
  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(w);
    send_word(w);
    @(negedge rng_clk);
    chk("cmp_no_valid", {31'd0, crngt_ehr_valid}, 32'd0);
    @(negedge rng_clk);
    chk("push_valid", {31'd0, crngt_ehr_valid}, 32'd1);
  endtask

  initial begin
    logic [15:0] sat_words[3];
    logic [15:0] sat_exp[3];
    sat_words = '{16'h9999, 16'hAAAA, 16'hBBBB};
    sat_exp   = '{16'hFFFE, 16'hFFFF, 16'hFFFF};

    // Reset values
    @(negedge rng_clk);
    chk("rst_rd",    {31'd0, crngt_collector_rd}, 32'd0);
    chk("rst_valid", {31'd0, crngt_ehr_valid}, 32'd0);
    chk("rst_data",  {16'd0, crngt_ehr_data}, 32'd0);
    chk("rst_err",   {31'd0, crngt_err}, 32'd0);
    chk("rst_cnt",   {16'd0, crngt_pass_cnt}, 32'd0);
    @(posedge rng_clk); #1;
    rst = 1'b0;
    crngt_en = 1'b1;
    ehr_crngt_ready = 1'b1;

    // First word only seeds the reference; next two are forwarded
    send_word(16'h1234);
    @(negedge rng_clk);
    @(negedge rng_clk);
    chk("first_no_push", {31'd0, crngt_ehr_valid}, 32'd0);
    push_word(16'h5678);
    push_word(16'hABCD);
    @(posedge rng_clk); #1;
    @(negedge rng_clk);
    chk("cnt_after_two", {16'd0, crngt_pass_cnt}, 32'd2);
    chk("err_after_two", {31'd0, crngt_err}, 32'd0);

    // Repeated word: error three cycles after the valid, then stuck in FAIL
    push_word(16'h1111);
    push_word(16'h2222);
    send_word(16'h2222);
    @(negedge rng_clk);
    chk("err_in_cmp", {31'd0, crngt_err}, 32'd0);
    @(negedge rng_clk);
    chk("err_set", {31'd0, crngt_err}, 32'd1);
    collector_valid = 1'b1;
    collector_crngt_data = 16'h3333;
    for (int i = 0; i < 6; i++) begin
      @(negedge rng_clk);
      chk("fail_no_rd", {31'd0, crngt_collector_rd}, 32'd0);
    end
    chk("fail_err_sticky", {31'd0, crngt_err}, 32'd1);
    chk("cnt_before_fail", {16'd0, crngt_pass_cnt}, 32'd4);
    collector_valid = 1'b0;

    // Soft reset leaves FAIL and re-arms the first-word handling
    @(posedge rng_clk); #1;
    rst_trng_logic = 1'b1;
    @(posedge rng_clk); #1;
    rst_trng_logic = 1'b0;
    @(negedge rng_clk);
    chk("soft_err", {31'd0, crngt_err}, 32'd0);
    chk("soft_cnt", {16'd0, crngt_pass_cnt}, 32'd0);
    chk("soft_data", {16'd0, crngt_ehr_data}, 32'd0);
    send_word(16'h2222);
    @(negedge rng_clk);
    @(negedge rng_clk);
    chk("soft_first_err", {31'd0, crngt_err}, 32'd0);
    chk("soft_first_nopush", {31'd0, crngt_ehr_valid}, 32'd0);
    push_word(16'h4444);
    @(posedge rng_clk); #1;
    @(negedge rng_clk);
    chk("soft_cnt_one", {16'd0, crngt_pass_cnt}, 32'd1);

    // Back-pressure: data held, next word already waiting is read two cycles after handshake
    @(posedge rng_clk); #1;
    ehr_crngt_ready = 1'b0;
    exp_q.push_back(16'h5555);
    exp_q.push_back(16'h6666);
    send_word(16'h5555);
    @(negedge rng_clk);
    collector_valid = 1'b1;
    collector_crngt_data = 16'h6666;
    for (int i = 0; i < 10; i++) begin
      @(negedge rng_clk);
      chk("stall_valid", {31'd0, crngt_ehr_valid}, 32'd1);
      chk("stall_data", {16'd0, crngt_ehr_data}, 32'h5555);
      chk("stall_no_rd", {31'd0, crngt_collector_rd}, 32'd0);
    end
    @(posedge rng_clk); #1;
    ehr_crngt_ready = 1'b1;
    @(negedge rng_clk);
    @(negedge rng_clk);
    chk("post_hs_wait_rd", {31'd0, crngt_collector_rd}, 32'd0);
    @(negedge rng_clk);
    chk("post_hs_rd", {31'd0, crngt_collector_rd}, 32'd1);
    @(posedge rng_clk); #1;
    collector_valid = 1'b0;
    @(negedge rng_clk);
    @(negedge rng_clk);
    @(posedge rng_clk); #1;
    @(negedge rng_clk);
    chk("cnt_after_stall", {16'd0, crngt_pass_cnt}, 32'd3);

    // Hard reset in the middle of a push drops the word
    @(posedge rng_clk); #1;
    ehr_crngt_ready = 1'b0;
    send_word(16'h7777);
    @(negedge rng_clk);
    @(negedge rng_clk);
    chk("pre_rst_valid", {31'd0, crngt_ehr_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, crngt_ehr_valid}, 32'd0);
    chk("async_rst_cnt", {16'd0, crngt_pass_cnt}, 32'd0);
    @(posedge rng_clk); #1;
    rst = 1'b0;
    ehr_crngt_ready = 1'b1;
    send_word(16'h7777);
    @(negedge rng_clk);
    @(negedge rng_clk);
    chk("rst_first_nopush", {31'd0, crngt_ehr_valid}, 32'd0);
    push_word(16'h8888);
    @(posedge rng_clk); #1;
    @(negedge rng_clk);
    chk("rst_cnt_one", {16'd0, crngt_pass_cnt}, 32'd1);

    // Saturation of the pass counter
    force dut.u_pass_cnt.cnt_q = 16'hFFFD;
    #1;
    release dut.u_pass_cnt.cnt_q;
    @(negedge rng_clk);
    chk("sat_preload", {16'd0, crngt_pass_cnt}, 32'hFFFD);
    for (int i = 0; i < 3; i++) begin
      push_word(sat_words[i]);
      @(posedge rng_clk); #1;
      @(negedge rng_clk);
      chk("sat_cnt", {16'd0, crngt_pass_cnt}, {16'd0, sat_exp[i]});
    end

    // Disabled: no reads even with a word offered
    @(posedge rng_clk); #1;
    crngt_en = 1'b0;
    @(posedge rng_clk); #1;
    collector_valid = 1'b1;
    collector_crngt_data = 16'hCCCC;
    for (int i = 0; i < 4; i++) begin
      @(negedge rng_clk);
      chk("disabled_no_rd", {31'd0, crngt_collector_rd}, 32'd0);
    end
    collector_valid = 1'b0;

    repeat (3) @(negedge rng_clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
